// File: rtl/led_pkg.sv
// Shared constants for the LED bank: channel mode encoding and tick rate.
package led_pkg;

  localparam int unsigned TICK_HZ = 1000;
  localparam int unsigned CHAN_W  = 5;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PULSE = 2'd3
  } mode_e;

endpackage

// File: rtl/led_bank_if.sv
// Configuration write channel (valid/ready) for the LED bank.
interface led_bank_if #(
  parameter int unsigned PERIOD_WIDTH = 16
);
  import led_pkg::*;

  logic                    Cfg_Valid;
  logic                    Cfg_Ready;
  logic [CHAN_W-1:0]       Cfg_Channel;
  logic [1:0]              Cfg_Mode;
  logic [PERIOD_WIDTH-1:0] Cfg_Half_Period;

  modport master (
    output Cfg_Valid, Cfg_Channel, Cfg_Mode, Cfg_Half_Period,
    input  Cfg_Ready
  );

  modport slave (
    input  Cfg_Valid, Cfg_Channel, Cfg_Mode, Cfg_Half_Period,
    output Cfg_Ready
  );

endinterface

// File: rtl/led_tick_gen.sv
// Free-running divider producing a one-cycle strobe at TICK_HZ.
module led_tick_gen #(
  parameter int unsigned CLOCK_FREQUENCY = 27000000,
  parameter int unsigned TICK_HZ         = 1000
) (
  input  logic Clock,
  input  logic Reset,
  output logic Tick
);

  localparam int unsigned TICK_DIV = (CLOCK_FREQUENCY / TICK_HZ < 1) ? 1 : CLOCK_FREQUENCY / TICK_HZ;
  localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = (count == LAST) ? '0 : count + 1'b1;
  end

  // Tick is registered alongside the count so it is high exactly while count == LAST
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count <= '0;
      Tick  <= 1'b0;
    end else begin
      count <= count_next;
      Tick  <= (count_next == LAST);
    end
  end

endmodule

// File: rtl/led_bank.sv
// Bank of independently configurable LED channels (off/on/blink/one-shot pulse).
module led_bank
  import led_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 27000000,
  parameter int unsigned NUM_LEDS        = 6,
  parameter int unsigned PERIOD_WIDTH    = 16,
  parameter int unsigned LED_ACTIVE_LOW  = 0
) (
  input  logic                Clock,
  input  logic                Reset,
  led_bank_if.slave           cfg,
  output logic [NUM_LEDS-1:0] Led,
  output logic                Ms_Tick,
  output logic [NUM_LEDS-1:0] Pulse_Done
);

  localparam logic [NUM_LEDS-1:0] LED_FILL = (LED_ACTIVE_LOW != 0) ? '1 : '0;

  logic                    accept;
  logic [PERIOD_WIDTH-1:0] half_load;
  logic [NUM_LEDS-1:0]     state_on;

  assign cfg.Cfg_Ready = ~Reset;
  assign accept        = cfg.Cfg_Valid & cfg.Cfg_Ready;
  assign half_load     = (cfg.Cfg_Half_Period == '0) ? PERIOD_WIDTH'(1) : cfg.Cfg_Half_Period;

  led_tick_gen #(
    .CLOCK_FREQUENCY (CLOCK_FREQUENCY),
    .TICK_HZ         (TICK_HZ)
  ) u_tick_gen (
    .Clock (Clock),
    .Reset (Reset),
    .Tick  (Ms_Tick)
  );

  for (genvar ch = 0; ch < NUM_LEDS; ch++) begin : g_chan
    mode_e                   mode;
    logic [PERIOD_WIDTH-1:0] half;
    logic [PERIOD_WIDTH-1:0] ms_cnt;
    logic                    phase;
    logic                    done;
    logic                    hit;
    logic                    timed;

    assign hit   = accept && (cfg.Cfg_Channel == CHAN_W'(ch));
    assign timed = (mode == MODE_BLINK) || (mode == MODE_PULSE);

    // A write takes priority over a coincident tick, which is then dropped
    always_ff @(posedge Clock) begin
      done <= 1'b0;
      if (Reset) begin
        mode   <= MODE_OFF;
        half   <= PERIOD_WIDTH'(1);
        ms_cnt <= '0;
        phase  <= 1'b0;
      end else if (hit) begin
        mode   <= mode_e'(cfg.Cfg_Mode);
        half   <= half_load;
        ms_cnt <= '0;
        phase  <= cfg.Cfg_Mode[1];
      end else if (Ms_Tick && timed) begin
        if (ms_cnt == half - 1'b1) begin
          ms_cnt <= '0;
          if (mode == MODE_PULSE) begin
            phase <= 1'b0;
            mode  <= MODE_OFF;
            done  <= 1'b1;
          end else begin
            phase <= ~phase;
          end
        end else begin
          ms_cnt <= ms_cnt + 1'b1;
        end
      end
    end

    assign state_on[ch]   = (mode == MODE_ON) || (timed && phase);
    assign Pulse_Done[ch] = done;
  end

  always_ff @(posedge Clock) begin
    if (Reset) Led <= LED_FILL;
    else       Led <= state_on ^ LED_FILL;
  end

endmodule

// File: tb/tb_led_bank.sv
// Randomised scoreboard bench for led_bank, checking active-high and active-low builds together.
module tb_led_bank;
  import led_pkg::*;

  localparam int unsigned N   = 6;
  localparam int unsigned PW  = 16;
  localparam int unsigned CF  = 10000;
  localparam int unsigned DIV = CF / 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_bank_if #(.PERIOD_WIDTH(PW)) if0 ();
  led_bank_if #(.PERIOD_WIDTH(PW)) if1 ();

  logic [N-1:0] led0, led1, done0, done1;
  logic         tick0, tick1;

  led_bank #(.CLOCK_FREQUENCY(CF), .NUM_LEDS(N), .PERIOD_WIDTH(PW), .LED_ACTIVE_LOW(0)) dut0 (
    .Clock(clk), .Reset(rst), .cfg(if0), .Led(led0), .Ms_Tick(tick0), .Pulse_Done(done0));

  led_bank #(.CLOCK_FREQUENCY(CF), .NUM_LEDS(N), .PERIOD_WIDTH(PW), .LED_ACTIVE_LOW(1)) dut1 (
    .Clock(clk), .Reset(rst), .cfg(if1), .Led(led1), .Ms_Tick(tick1), .Pulse_Done(done1));

  typedef struct {
    logic [N-1:0] led0;
    logic [N-1:0] led1;
    logic         tick;
    logic [N-1:0] done;
    logic         ready;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: per channel, ticks elapsed since the last write
  int       cyc;
  bit       m_tick;
  int       m_mode[N];
  int       m_hp[N];
  int       m_k[N];
  bit [N-1:0] m_logic;

  function automatic bit [N-1:0] logic_of();
    bit [N-1:0] r;
    r = '0;
    for (int c = 0; c < N; c++) begin
      case (m_mode[c])
        1:       r[c] = 1'b1;
        2:       r[c] = ((m_k[c] / m_hp[c]) % 2) == 0;
        3:       r[c] = 1'b1;
        default: r[c] = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic step(input bit r, input bit v, input int ch, input int md, input int hp);
    exp_t       e;
    bit [N-1:0] dn;
    bit         prev_tick;
    @(negedge clk);
    rst = r;
    if0.Cfg_Valid = v; if0.Cfg_Channel = 5'(ch); if0.Cfg_Mode = 2'(md); if0.Cfg_Half_Period = 16'(hp);
    if1.Cfg_Valid = v; if1.Cfg_Channel = 5'(ch); if1.Cfg_Mode = 2'(md); if1.Cfg_Half_Period = 16'(hp);
    dn = '0;
    prev_tick = m_tick;
    if (r) begin
      e.led0 = '0;
      e.led1 = '1;
      cyc = 0;
      m_tick = 1'b0;
      for (int c = 0; c < N; c++) begin
        m_mode[c] = 0; m_hp[c] = 1; m_k[c] = 0;
      end
    end else begin
      e.led0 = m_logic;
      e.led1 = ~m_logic;
      cyc++;
      m_tick = (cyc % DIV) == (DIV - 1);
      for (int c = 0; c < N; c++) begin
        if (v && ch == c) begin
          m_mode[c] = md;
          m_hp[c]   = (hp == 0) ? 1 : hp;
          m_k[c]    = 0;
        end else if (prev_tick && m_mode[c] >= 2) begin
          m_k[c]++;
          if (m_mode[c] == 3 && m_k[c] == m_hp[c]) begin
            m_mode[c] = 0;
            dn[c] = 1'b1;
          end
        end
      end
    end
    m_logic = logic_of();
    e.tick  = m_tick;
    e.done  = dn;
    e.ready = !r;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: DUT outputs are sampled every cycle, 1 time unit after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("led_active_high", 32'(led0), 32'(e.led0));
        check("led_active_low",  32'(led1), 32'(e.led1));
        check("ms_tick0",        32'(tick0), 32'(e.tick));
        check("ms_tick1",        32'(tick1), 32'(e.tick));
        check("pulse_done0",     32'(done0), 32'(e.done));
        check("pulse_done1",     32'(done1), 32'(e.done));
        check("cfg_ready0",      32'(if0.Cfg_Ready), 32'(e.ready));
        check("cfg_ready1",      32'(if1.Cfg_Ready), 32'(e.ready));
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b1;
    if0.Cfg_Valid = 1'b0; if0.Cfg_Channel = '0; if0.Cfg_Mode = '0; if0.Cfg_Half_Period = '0;
    if1.Cfg_Valid = 1'b0; if1.Cfg_Channel = '0; if1.Cfg_Mode = '0; if1.Cfg_Half_Period = '0;
    cyc = 0; m_tick = 1'b0; m_logic = '0;
    for (int c = 0; c < N; c++) begin
      m_mode[c] = 0; m_hp[c] = 1; m_k[c] = 0;
    end

    // Reset then idle: tick cadence, LEDs dark
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 0);
    idle(25);

    // ch0 blink, 5 full periods
    step(1'b0, 1'b1, 0, 2, 3);
    idle(310);

    // ch5 one-shot pulse
    step(1'b0, 1'b1, 5, 3, 2);
    idle(40);

    // ch2 blink with zero half-period, written in a tick cycle
    guard = 0;
    while (!m_tick && guard < 2 * DIV) begin
      idle(1);
      guard++;
    end
    step(1'b0, 1'b1, 2, 2, 0);
    idle(30);

    // Out-of-range write, then reset in the middle of a pulse
    step(1'b0, 1'b1, 7, 1, 4);
    idle(3);
    step(1'b0, 1'b1, 3, 1, 1);
    step(1'b0, 1'b1, 1, 3, 5);
    idle(20);
    step(1'b1, 1'b1, 4, 1, 1);
    step(1'b1, 1'b0, 0, 0, 0);
    idle(60);

    // Random traffic including mid-pulse/mid-blink rewrites
    for (int i = 0; i < 2000; i++) begin
      int hp;
      hp = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 4));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), hp);
    end

    idle(2);
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_bank.md
LED_BANK -- requirements
Module: led_bank

Interface
REQ-001 The module SHALL have parameter CLOCK_FREQUENCY, default 27000000, giving the input clock rate in Hz.
REQ-002 The module SHALL have parameter NUM_LEDS, default 6, giving the channel count (1..32).
REQ-003 The module SHALL have parameter PERIOD_WIDTH, default 16, giving the half-period field width in ms units.
REQ-004 The module SHALL have parameter LED_ACTIVE_LOW, default 0; when 1, every Led bit is inverted at the output.
REQ-005 The module SHALL have port Clock, input, 1 bit: the single clock.
REQ-006 The module SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port Cfg_Valid, input, 1 bit: a configuration write is offered.
REQ-008 The module SHALL have port Cfg_Ready, output, 1 bit: a configuration write can be accepted.
REQ-009 The module SHALL have port Cfg_Channel, input, 5 bits: the target channel index.
REQ-010 The module SHALL have port Cfg_Mode, input, 2 bits: 0 OFF, 1 ON, 2 BLINK, 3 PULSE.
REQ-011 The module SHALL have port Cfg_Half_Period, input, PERIOD_WIDTH bits: the half-period in ms.
REQ-012 The module SHALL have port Led, output, NUM_LEDS bits: the registered LED drive.
REQ-013 The module SHALL have port Ms_Tick, output, 1 bit: a one-cycle strobe every 1 ms.
REQ-014 The module SHALL have port Pulse_Done, output, NUM_LEDS bits: a one-cycle strobe per channel when its PULSE completes.

Function
REQ-015 The tick generator SHALL count 0..TICK_DIV-1, where TICK_DIV = CLOCK_FREQUENCY/1000, and SHALL assert Ms_Tick for exactly the cycle in which the count equals TICK_DIV-1, then wrap to 0.
REQ-016 A configuration write SHALL be accepted in any cycle where Cfg_Valid and Cfg_Ready are both 1; Cfg_Ready SHALL be 1 in every cycle except while Reset is asserted.
REQ-017 A write with Cfg_Channel >= NUM_LEDS SHALL be accepted and ignored, with no state change.
REQ-018 An accepted write SHALL, from the next cycle, load the channel's mode and half-period, clear its ms counter to 0, and set its phase to 1 for BLINK/PULSE or to 0 for OFF/ON.
REQ-019 A Cfg_Half_Period value of 0 SHALL be stored as 1.
REQ-020 In a BLINK channel, on each Ms_Tick the ms counter SHALL increment; when it equals half_period-1 it SHALL wrap to 0 and the phase SHALL toggle, giving a square wave of period 2*half_period ms.
REQ-021 In a PULSE channel, the phase SHALL be 1 for half_period ms; on the wrap tick the phase SHALL clear, the mode SHALL become OFF, and Pulse_Done[ch] SHALL be asserted for one cycle.
REQ-022 The logical LED state SHALL be: OFF gives 0, ON gives 1, and BLINK/PULSE give the phase.
REQ-023 Led[ch] SHALL be registered, equal the logical state XOR LED_ACTIVE_LOW, and follow a state change by 1 cycle.
REQ-024 When a write and Ms_Tick hit the same channel in the same cycle, the write SHALL win and that tick SHALL be discarded for that channel.
REQ-025 A write to a channel mid-pulse or mid-blink SHALL restart that channel without asserting Pulse_Done.
REQ-026 All channels SHALL advance on the same Ms_Tick; channels not written in a cycle SHALL be unaffected.

Reset
REQ-027 While Reset is 1, the tick counter, all ms counters, phases and Pulse_Done SHALL clear to 0, every mode SHALL become OFF, every half-period SHALL become 1, and Ms_Tick and Cfg_Ready SHALL be 0.
REQ-028 Led SHALL reset to all-0 when LED_ACTIVE_LOW = 0, or all-1 when LED_ACTIVE_LOW = 1.
REQ-029 Reset asserted mid-operation SHALL abort every channel on the next edge; no Pulse_Done SHALL be produced for aborted pulses.

Structure
REQ-030 The mode encoding constants (MODE_OFF, MODE_ON, MODE_BLINK, MODE_PULSE) and the 1000 Hz tick-rate constant SHALL live in shared package led_pkg.
REQ-031 The tick generator SHALL be a separate sub-module led_tick_gen, with parameters CLOCK_FREQUENCY and TICK_HZ, and ports Clock, Reset and Tick.
REQ-032 The per-channel logic SHALL be a generate loop inside led_bank, with no further sub-modules.

Verification (CLOCK_FREQUENCY=10000, so TICK_DIV=10; NUM_LEDS=6; LED_ACTIVE_LOW=0)
REQ-033 Release Reset -> the first Ms_Tick is asserted on the 10th cycle after release, then every 10 cycles; Led stays 000000.
REQ-034 Write ch0 BLINK with half-period 3 -> Led[0]=1 next cycle, then toggles every 30 cycles (3 ticks), for 5 full periods.
REQ-035 Write ch5 PULSE with half-period 2 -> Led[5] is high for 2 ticks, Pulse_Done[5] is a single-cycle strobe on the wrap tick, and Led[5] then stays 0.
REQ-036 Write ch2 BLINK with half-period 0 coincident with Ms_Tick -> the period is stored as 1, the write wins, and Led[2] toggles on every subsequent tick.
REQ-037 Write ch7 ON -> no Led change; then write ch3 ON and ch1 PULSE, and assert Reset mid-pulse -> Led=000000, no Pulse_Done, and Cfg_Ready is 0 during reset.
REQ-038 Repeat REQ-034 with LED_ACTIVE_LOW=1 -> the Led waveform is inverted and reset drives all-1.
